// File: rtl/alu_top.sv
// alu_top: registered signed 16-bit ALU (arith/logic/compare/shift units).
// Define ALU_DIV_EN to compile in the signed divider for function 0011.
module alu_top #(
   parameter int width       = 16,
   parameter int arith_width = 2 * width,
   parameter int logic_width = width,
   parameter int cmp_width   = 3,
   parameter int shift_width = width + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [width-1:0]       a,
   input  logic signed [width-1:0]       b,
   input  logic        [3:0]             alu_func,
   output logic signed [arith_width-1:0] arith_out,
   output logic                          carry_out,
   output logic        [logic_width-1:0] logic_out,
   output logic        [cmp_width-1:0]   cmp_out,
   output logic        [shift_width-1:0] shift_out,
   output logic                          arith_flag,
   output logic                          logic_flag,
   output logic                          cmp_flag,
   output logic                          shift_flag
);

   typedef enum logic [1:0] {
      UNIT_ARITH = 2'b00,
      UNIT_LOGIC = 2'b01,
      UNIT_CMP   = 2'b10,
      UNIT_SHIFT = 2'b11
   } unit_e;

   unit_e unit;
   logic  is_arith;
   logic  is_logic;
   logic  is_cmp;
   logic  is_shift;

   assign unit     = unit_e'(alu_func[3:2]);
   assign is_arith = (unit == UNIT_ARITH);
   assign is_logic = (unit == UNIT_LOGIC);
   assign is_cmp   = (unit == UNIT_CMP);
   assign is_shift = (unit == UNIT_SHIFT);

   logic signed [arith_width-1:0] a_ext;
   logic signed [arith_width-1:0] b_ext;
   logic        [width:0]         add_u;
   logic        [width:0]         sub_u;
   logic signed [arith_width-1:0] div_q;

   assign a_ext = {{(arith_width-width){a[width-1]}}, a};
   assign b_ext = {{(arith_width-width){b[width-1]}}, b};

   // width-bit unsigned carries; sub uses a + ~b + 1
   assign add_u = {1'b0, a} + {1'b0, b};
   assign sub_u = {1'b0, a} + {1'b0, ~b}
                + {{width{1'b0}}, 1'b1};

`ifdef ALU_DIV_EN
   // 32-bit operands keep -32768 / -1 exact
   always_comb begin
      div_q = '0;
      if (b != '0)
         div_q = a_ext / b_ext;
   end
`else
   assign div_q = '0;
`endif

   logic signed [arith_width-1:0] nxt_arith;
   logic                          nxt_carry;
   logic        [logic_width-1:0] nxt_logic;
   logic        [cmp_width-1:0]   nxt_cmp;
   logic        [shift_width-1:0] nxt_shift;
   logic        [3:0]             nxt_flags;
   logic        [3:0]             flags_q;

   always_comb begin
      nxt_arith = '0;
      nxt_carry = 1'b0;
      nxt_logic = '0;
      nxt_cmp   = '0;
      nxt_shift = '0;
      nxt_flags = '0;
      unique case (1'b1)
         is_arith: begin
            nxt_flags = 4'b1000;
            unique case (alu_func[1:0])
               2'b00: begin
                  nxt_arith = a_ext + b_ext;
                  nxt_carry = add_u[width];
               end
               2'b01: begin
                  nxt_arith = a_ext - b_ext;
                  nxt_carry = sub_u[width];
               end
               2'b10: nxt_arith = a_ext * b_ext;
               default: nxt_arith = div_q;
            endcase
         end
         is_logic: begin
            nxt_flags = 4'b0100;
            unique case (alu_func[1:0])
               2'b00: nxt_logic = a & b;
               2'b01: nxt_logic = a | b;
               2'b10: nxt_logic = ~(a & b);
               default: nxt_logic = ~(a | b);
            endcase
         end
         is_cmp: begin
            nxt_flags = 4'b0010;
            unique case (alu_func[1:0])
               2'b01: begin
                  if (a == b)
                     nxt_cmp = 3'd1;
               end
               2'b10: begin
                  if (a > b)
                     nxt_cmp = 3'd2;
               end
               2'b11: begin
                  if (a < b)
                     nxt_cmp = 3'd3;
               end
               default: nxt_cmp = '0;
            endcase
         end
         is_shift: begin
            nxt_flags = 4'b0001;
            unique case (alu_func[1:0])
               2'b00: nxt_shift = {1'b0, a} >> 1;
               2'b01: nxt_shift = {a, 1'b0};
               2'b10: nxt_shift = {1'b0, b} >> 1;
               default: nxt_shift = {b, 1'b0};
            endcase
         end
         default: nxt_flags = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arith_out <= '0;
         carry_out <= 1'b0;
         logic_out <= '0;
         cmp_out   <= '0;
         shift_out <= '0;
         flags_q   <= '0;
      end else begin
         arith_out <= nxt_arith;
         carry_out <= nxt_carry;
         logic_out <= nxt_logic;
         cmp_out   <= nxt_cmp;
         shift_out <= nxt_shift;
         flags_q   <= nxt_flags;
      end
   end

   assign arith_flag = flags_q[3];
   assign logic_flag = flags_q[2];
   assign cmp_flag   = flags_q[1];
   assign shift_flag = flags_q[0];

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: directed plus random checks of alu_top against a
// behavioural integer model.
module tb_alu_top;

   logic               clk;
   logic               rst;
   logic signed [15:0] a;
   logic signed [15:0] b;
   logic        [3:0]  alu_func;
   logic signed [31:0] arith_out;
   logic               carry_out;
   logic        [15:0] logic_out;
   logic        [2:0]  cmp_out;
   logic        [16:0] shift_out;
   logic               arith_flag;
   logic               logic_flag;
   logic               cmp_flag;
   logic               shift_flag;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] arith;
      logic        carry;
      logic [15:0] lg;
      logic [2:0]  cmp;
      logic [16:0] sh;
      logic [3:0]  flags;
   } exp_t;

   alu_top dut (
      .clk        (clk),
      .rst        (rst),
      .a          (a),
      .b          (b),
      .alu_func   (alu_func),
      .arith_out  (arith_out),
      .carry_out  (carry_out),
      .logic_out  (logic_out),
      .cmp_out    (cmp_out),
      .shift_out  (shift_out),
      .arith_flag (arith_flag),
      .logic_flag (logic_flag),
      .cmp_flag   (cmp_flag),
      .shift_flag (shift_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] f,
                                  input logic [15:0] x,
                                  input logic [15:0] y);
      exp_t e;
      int sa;
      int sb;
      int ua;
      int ub;
      int r;
      e  = '0;
      sa = int'($signed(x));
      sb = int'($signed(y));
      ua = int'({16'h0, x});
      ub = int'({16'h0, y});
      r  = 0;
      case (f[3:2])
         2'd0: begin
            e.flags = 4'b1000;
            case (f[1:0])
               2'd0: begin
                  r = sa + sb;
                  e.carry = (ua + ub) > 65535;
               end
               2'd1: begin
                  r = sa - sb;
                  e.carry = (ua + (65535 - ub) + 1) > 65535;
               end
               2'd2: r = sa * sb;
               default: begin
`ifdef ALU_DIV_EN
                  r = (sb == 0) ? 0 : sa / sb;
`else
                  r = 0;
`endif
               end
            endcase
            e.arith = r;
         end
         2'd1: begin
            e.flags = 4'b0100;
            case (f[1:0])
               2'd0: e.lg = x & y;
               2'd1: e.lg = x | y;
               2'd2: e.lg = ~(x & y);
               default: e.lg = ~(x | y);
            endcase
         end
         2'd2: begin
            e.flags = 4'b0010;
            case (f[1:0])
               2'd1: e.cmp = (sa == sb) ? 3'd1 : 3'd0;
               2'd2: e.cmp = (sa > sb) ? 3'd2 : 3'd0;
               2'd3: e.cmp = (sa < sb) ? 3'd3 : 3'd0;
               default: e.cmp = 3'd0;
            endcase
         end
         default: begin
            e.flags = 4'b0001;
            case (f[1:0])
               2'd0: e.sh = 17'(ua / 2);
               2'd1: e.sh = 17'(ua * 2);
               2'd2: e.sh = 17'(ub / 2);
               default: e.sh = 17'(ub * 2);
            endcase
         end
      endcase
      return e;
   endfunction

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check({tag, ".arith"}, arith_out, e.arith);
      check({tag, ".carry"}, {31'b0, carry_out}, {31'b0, e.carry});
      check({tag, ".logic"}, {16'b0, logic_out}, {16'b0, e.lg});
      check({tag, ".cmp"}, {29'b0, cmp_out}, {29'b0, e.cmp});
      check({tag, ".shift"}, {15'b0, shift_out}, {15'b0, e.sh});
      check({tag, ".flags"},
            {28'b0, arith_flag, logic_flag, cmp_flag, shift_flag},
            {28'b0, e.flags});
   endtask

   task automatic step(input logic [3:0] f, input int x, input int y,
                       input string tag);
      logic [15:0] xv;
      logic [15:0] yv;
      xv = x[15:0];
      yv = y[15:0];
      alu_func = f;
      a = xv;
      b = yv;
      @(posedge clk);
      #1;
      check_all(tag, model(f, xv, yv));
   endtask

   int pa[4]      = '{-100, 100, -100, 100};
   int pb[4]      = '{-30, -30, 30, 30};
   int exp_add[4] = '{-130, 70, -70, 130};
   int exp_sub[4] = '{-70, 130, -130, 70};
   int exp_mul[4] = '{3000, -3000, -3000, 3000};
   int exp_div[4] = '{3, -3, -3, 3};
   int exp_sh[4]  = '{50, 200, 15, 60};
   int exp_lg[4]  = '{32'hFF80, 32'hFFFE, 32'h007F, 32'h0001};
   int exp_cmp[4] = '{0, 0, 2, 0};

   initial begin
      exp_t hold_e;
      logic [3:0] rf;
      int ra;
      int rb;

      rst = 1'b0;
      alu_func = 4'b0000;
      a = -16'sd100;
      b = -16'sd30;
      #2;
      check_all("reset", '0);
      rst = 1'b1;
      step(4'b0000, -100, -30, "release");
      check("release.val", arith_out, -32'sd130);

      for (int i = 0; i < 4; i++) begin
         step(4'b0000, pa[i], pb[i], "add");
         check("add.val", arith_out, exp_add[i]);
         step(4'b0001, pa[i], pb[i], "sub");
         check("sub.val", arith_out, exp_sub[i]);
         step(4'b0010, pa[i], pb[i], "mul");
         check("mul.val", arith_out, exp_mul[i]);
         step(4'b0011, pa[i], pb[i], "div");
`ifdef ALU_DIV_EN
         check("div.val", arith_out, exp_div[i]);
`else
         check("div.val", arith_out, 32'd0);
`endif
      end
      step(4'b0011, 100, 0, "div0");
      check("div0.val", arith_out, 32'd0);
      step(4'b0011, -32768, -1, "divovf");

      for (int i = 0; i < 4; i++) begin
         step(4'(4 + i), -100, -30, "logic");
         check("logic.val", {16'b0, logic_out}, exp_lg[i]);
         step(4'(8 + i), 100, 30, "cmp");
         check("cmp.val", {29'b0, cmp_out}, exp_cmp[i]);
         step(4'(12 + i), 100, 30, "shift");
         check("shift.val", {15'b0, shift_out}, exp_sh[i]);
      end
      step(4'b1001, 5, 5, "cmp_eq");
      check("cmp_eq.val", {29'b0, cmp_out}, 32'd1);
      step(4'b1011, -5, 3, "cmp_lt");
      check("cmp_lt.val", {29'b0, cmp_out}, 32'd3);
      step(4'b1101, 32'h8000, 0, "shl_msb");
      check("shl_msb.val", {15'b0, shift_out}, 32'h10000);
      step(4'b0000, 65535, 1, "carry_add");
      step(4'b0001, 5, 5, "carry_sub");

      hold_e = model(4'b0010, 16'd300, 16'hFFF9);
      step(4'b0010, 300, -7, "hold_pre");
      alu_func = 4'b0101;
      a = 16'h1234;
      b = 16'h00FF;
      #2;
      check_all("hold", hold_e);

      for (int i = 0; i < 300; i++) begin
         rf = 4'($urandom_range(0, 15));
         ra = int'($urandom & 32'hFFFF);
         rb = ($urandom_range(0, 9) == 0) ? 0
            : int'($urandom & 32'hFFFF);
         step(rf, ra, rb, "rand");
      end

      step(4'b0000, 100, 30, "pre_rst");
      #2;
      rst = 1'b0;
      #1;
      check_all("async_rst", '0);
      @(posedge clk);
      #1;
      check_all("rst_hold", '0);
      rst = 1'b1;
      step(4'b1110, 100, 30, "post_rst");
      check("post_rst.val", {15'b0, shift_out}, 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
